bcd_ctr_n: RTL and testbench
============================

Name: bcd_ctr_n

Overview:
- Parametrised N-digit BCD up/down counter with synchronous clear, parallel load and enable.
- Adds two things a fixed two-digit 00–99 counter lacks: a runtime-programmable terminal value Lim (e.g. 59 for a minutes field), and a per-instance choice of wrap or saturate at the ends.
- Load values are validated; out-of-range loads are clamped and flagged.
- Used as the time/score field building block in the display datapath; cascades via Co/Bo.

Parameters:
- DIGITS, 2, number of BCD digits; Q/D/Lim width = 4*DIGITS; legal range 1–8.
- SATURATE, 0, 0 = wrap at the ends, 1 = hold at the ends.

Ports:
- Clk  in  1  single clock, rising edge.
- Clr  in  1  reset; synchronous, active-high; forces Q to 0.
- En  in  1  count enable.
- Ld  in  1  parallel load; does not need En.
- Up  in  1  1 = count up, 0 = count down.
- D  in  4*DIGITS  load value, BCD, digit 0 in bits [3:0].
- Lim  in  4*DIGITS  terminal value, BCD.
- Q  out  4*DIGITS  registered count, BCD.
- Co  out  1  combinational terminal-up flag: En & Up & (Q >= Lim).
- Bo  out  1  combinational terminal-down flag: En & ~Up & (Q == 0).
- Err  out  1  registered, one-cycle pulse on a rejected/clamped load.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (Clk, Clr).
- Reset values: Q = 0, Err = 0. Co and Bo then follow from Q = 0.
- Priority each rising edge: Clr > Ld > En. Err is 0 on any cycle without an effective load.
- Lim sanitisation: any Lim digit > 9 is treated as 9 (giving Lim_s). All comparisons are BCD-magnitude, most significant digit first.
- Load, valid: all D digits ≤ 9 and D ≤ Lim_s → Q = D next cycle, Err = 0.
- Load, invalid: any D digit > 9 or D > Lim_s → Q = Lim_s, Err = 1 for exactly one cycle.
- Count up (En & ~Ld & Up):
  - Q < Lim_s → Q + 1, decimal carry rippling across digits (e.g. 09 → 10, 199 → 200).
  - Q ≥ Lim_s → Q = 0 if SATURATE = 0; Q = Lim_s if SATURATE = 1.
- Count down (En & ~Ld & ~Up):
  - 0 < Q ≤ Lim_s → Q − 1, decimal borrow (10 → 09, 200 → 199).
  - Q = 0 → Q = Lim_s if SATURATE = 0; hold 0 if SATURATE = 1.
  - Q > Lim_s (Lim lowered at runtime) → Q = Lim_s.
- En = 0 with no Ld/Clr: Q holds, Co = Bo = 0.
- Lim = 0: Q stays 0; Co is high whenever En & Up; Bo is high whenever En & ~Up.
- Cascading: Co/Bo have no registered delay. A downstream instance's En is driven from Co or Bo and advances on the same edge.
- Clr with Ld or En asserted: Clr wins, Q = 0, Err = 0.
- Lim changing mid-count takes effect on the very next edge; no stale value is used.
- Outputs never present a non-BCD digit under any input sequence.

Decomposition:
- Package bcd_pkg:
  - constants DIGIT_W = 4 and BCD_MAX = 4'd9;
  - function bcd_gt(a, b, n) — magnitude compare;
  - function bcd_sanitise(v, n) — clamp digits to 9.
- Sub-module bcd_digit: one combinational digit stage.
  - Inputs: digit value, Up, carry/borrow in.
  - Outputs: next digit value, carry/borrow out.
  - Instantiated DIGITS times through a generate loop.
- Top level holds the Q register, priority mux, load validation and the Err register.

Test Plan:
- DIGITS=2, Lim=99, SATURATE=0, Up=1, En=1 from Clr → Q walks 00..99, Co=1 only at 99, then 00 on the next edge; 09 → 10 verified.
- Lim=59, Up=0, En=1 from Q=00 → Bo=1 at 00, next Q=59, then 58; SATURATE=1 variant holds 00 with Bo high.
- Ld=1, En=0, D=0x47 with Lim=59 → Q=47, Err=0; D=0x3A → Q=59, Err=1 for one cycle; D=0x75 → Q=59, Err=1.
- Q=50, then lower Lim to 0x30 while counting down → next Q=30; counting up from there → next Q=00.
- Clr, Ld and En asserted in the same cycle with Q=42 → Q=00, Err=0; Clr mid-count at Q=57 → 00 next edge.
- DIGITS=3 counting up from 199 → 200; two cascaded 2-digit instances (low Co → high En) roll 0099 → 0100 on one edge.

Source files
------------

// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_pkg
// Purpose  : Shared constants and BCD helper functions for the BCD counter.
// Revision : 1.0 - initial release
// ============================================================================
package bcd_pkg;

  localparam int         DIGIT_W    = 4;
  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam int         MAX_DIGITS = 8;
  localparam int         MAX_W      = DIGIT_W * MAX_DIGITS;

  // Magnitude compare a > b over the lowest n digits, most significant first.
  function automatic logic bcd_gt(input logic [MAX_W-1:0] a,
                                  input logic [MAX_W-1:0] b,
                                  input int n);
    logic res;
    logic done;
    res  = 1'b0;
    done = 1'b0;
    for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
      if (i < n && !done) begin
        if (a[i*DIGIT_W +: DIGIT_W] > b[i*DIGIT_W +: DIGIT_W]) begin
          res  = 1'b1;
          done = 1'b1;
        end else if (a[i*DIGIT_W +: DIGIT_W] < b[i*DIGIT_W +: DIGIT_W]) begin
          done = 1'b1;
        end
      end
    end
    return res;
  endfunction

  // Clamp every digit above 9 down to 9 over the lowest n digits.
  function automatic logic [MAX_W-1:0] bcd_sanitise(input logic [MAX_W-1:0] v,
                                                    input int n);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < n) begin
        r[i*DIGIT_W +: DIGIT_W] = (v[i*DIGIT_W +: DIGIT_W] > BCD_MAX) ?
                                  BCD_MAX : v[i*DIGIT_W +: DIGIT_W];
      end
    end
    return r;
  endfunction

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bcd_digit.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit
// Purpose  : One combinational BCD digit stage of an increment/decrement
//            ripple chain (carry when counting up, borrow when counting down).
// Revision : 1.0 - initial release
// ============================================================================
module bcd_digit
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] dig_i,
  input  logic               up_i,
  input  logic               c_i,
  output logic [DIGIT_W-1:0] dig_o,
  output logic               c_o
);

  // Step the digit only when the lower stages ripple into it.
  always_comb begin
    dig_o = dig_i;
    c_o   = 1'b0;
    if (c_i) begin
      if (up_i) begin
        // >= keeps the output BCD even if a non-BCD digit ever arrived
        if (dig_i >= BCD_MAX) begin
          dig_o = '0;
          c_o   = 1'b1;
        end else begin
          dig_o = dig_i + 4'd1;
        end
      end else begin
        if (dig_i == '0) begin
          dig_o = BCD_MAX;
          c_o   = 1'b1;
        end else begin
          dig_o = dig_i - 4'd1;
        end
      end
    end
  end

endmodule : bcd_digit
`default_nettype wire

// File: rtl/bcd_ctr_n.sv
`default_nettype none
// ============================================================================
// Module   : bcd_ctr_n
// Purpose  : N-digit BCD up/down counter with runtime terminal value,
//            validated parallel load, wrap/saturate ends and cascade flags.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_ctr_n
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 2,
  parameter bit SATURATE = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  clr_i,
  input  logic                  en_i,
  input  logic                  ld_i,
  input  logic                  up_i,
  input  logic [4*DIGITS-1:0]   d_i,
  input  logic [4*DIGITS-1:0]   lim_i,
  output logic [4*DIGITS-1:0]   q_o,
  output logic                  co_o,
  output logic                  bo_o,
  output logic                  err_o
);

  localparam int W = DIGIT_W * DIGITS;

  logic [W-1:0]  q_q, q_d;
  logic          err_q, err_d;
  logic [W-1:0]  w_lim_s;
  logic [W-1:0]  w_step;
  logic [DIGITS:0] w_chain;
  logic          w_q_zero, w_q_ge_lim, w_q_gt_lim;
  logic          w_d_digits_ok, w_ld_valid;

  // Sanitised terminal value and the comparisons everything else keys off.
  always_comb begin
    w_lim_s       = W'(bcd_sanitise(MAX_W'(lim_i), DIGITS));
    w_q_zero      = (q_q == '0);
    w_q_ge_lim    = !bcd_gt(MAX_W'(w_lim_s), MAX_W'(q_q), DIGITS);
    w_q_gt_lim    = bcd_gt(MAX_W'(q_q), MAX_W'(w_lim_s), DIGITS);
    w_d_digits_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (d_i[i*DIGIT_W +: DIGIT_W] > BCD_MAX) w_d_digits_ok = 1'b0;
    end
    w_ld_valid = w_d_digits_ok && !bcd_gt(MAX_W'(d_i), MAX_W'(w_lim_s), DIGITS);
  end

  // Ripple chain: digit 0 always steps, each higher digit steps on carry/borrow.
  assign w_chain[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .dig_i (q_q[g*DIGIT_W +: DIGIT_W]),
      .up_i  (up_i),
      .c_i   (w_chain[g]),
      .dig_o (w_step[g*DIGIT_W +: DIGIT_W]),
      .c_o   (w_chain[g+1])
    );
  end

  // Next-state priority: clear, then load, then count.
  always_comb begin
    q_d   = q_q;
    err_d = 1'b0;
    if (clr_i) begin
      q_d = '0;
    end else if (ld_i) begin
      q_d   = w_ld_valid ? d_i : w_lim_s;
      err_d = !w_ld_valid;
    end else if (en_i) begin
      if (up_i) begin
        // chain overflow only occurs at all-nines, which is always >= limit
        if (w_q_ge_lim || w_chain[DIGITS]) q_d = SATURATE ? w_lim_s : '0;
        else                               q_d = w_step;
      end else begin
        if (w_q_zero || w_chain[DIGITS]) q_d = SATURATE ? '0 : w_lim_s;
        else if (w_q_gt_lim)             q_d = w_lim_s;
        else                             q_d = w_step;
      end
    end
  end

  // Count and load-error registers.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      q_q   <= '0;
      err_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      err_q <= err_d;
    end
  end

  assign q_o   = q_q;
  assign err_o = err_q;
  assign co_o  = en_i &  up_i & w_q_ge_lim;
  assign bo_o  = en_i & ~up_i & w_q_zero;

endmodule : bcd_ctr_n
`default_nettype wire

// File: tb/tb_bcd_ctr_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_ctr_n
// Purpose  : Directed self-checking bench for bcd_ctr_n (wrap, saturate,
//            three-digit and cascaded configurations).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_ctr_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Group A: wrap and saturate instances driven identically
  logic       clr, en, ld, up;
  logic [7:0] d, lim;
  logic [7:0] qw, qs;
  logic       cow, bow, errw, cos, bos, errs;
  // Group B: three digits
  logic        en3, ld3, up3;
  logic [11:0] d3, lim3, q3;
  logic        co3, bo3, err3;
  // Group C: cascaded pair
  logic       ld_c, en_c, up_c;
  logic [7:0] d_lo, d_hi, lim_c, q_lo, q_hi;
  logic       co_lo, bo_lo, err_lo, co_hi, bo_hi, err_hi;

  bcd_ctr_n #(.DIGITS(2), .SATURATE(1'b0)) u_wrap (
    .clk_i(clk), .clr_i(clr), .en_i(en), .ld_i(ld), .up_i(up), .d_i(d), .lim_i(lim),
    .q_o(qw), .co_o(cow), .bo_o(bow), .err_o(errw));

  bcd_ctr_n #(.DIGITS(2), .SATURATE(1'b1)) u_sat (
    .clk_i(clk), .clr_i(clr), .en_i(en), .ld_i(ld), .up_i(up), .d_i(d), .lim_i(lim),
    .q_o(qs), .co_o(cos), .bo_o(bos), .err_o(errs));

  bcd_ctr_n #(.DIGITS(3), .SATURATE(1'b0)) u_d3 (
    .clk_i(clk), .clr_i(clr), .en_i(en3), .ld_i(ld3), .up_i(up3), .d_i(d3), .lim_i(lim3),
    .q_o(q3), .co_o(co3), .bo_o(bo3), .err_o(err3));

  bcd_ctr_n #(.DIGITS(2), .SATURATE(1'b0)) u_lo (
    .clk_i(clk), .clr_i(clr), .en_i(en_c), .ld_i(ld_c), .up_i(up_c), .d_i(d_lo), .lim_i(lim_c),
    .q_o(q_lo), .co_o(co_lo), .bo_o(bo_lo), .err_o(err_lo));

  bcd_ctr_n #(.DIGITS(2), .SATURATE(1'b0)) u_hi (
    .clk_i(clk), .clr_i(clr), .en_i(co_lo), .ld_i(ld_c), .up_i(up_c), .d_i(d_hi), .lim_i(lim_c),
    .q_o(q_hi), .co_o(co_hi), .bo_o(bo_hi), .err_o(err_hi));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  initial begin
    clr = 1'b1; en = 1'b0; ld = 1'b0; up = 1'b1; d = 8'h00; lim = 8'h99;
    en3 = 1'b0; ld3 = 1'b0; up3 = 1'b1; d3 = 12'h000; lim3 = 12'h999;
    ld_c = 1'b0; en_c = 1'b0; up_c = 1'b1; d_lo = 8'h00; d_hi = 8'h00; lim_c = 8'h99;

    // reset state
    tick();
    clr = 1'b0;
    #1;
    chk("rst_q_wrap", 32'(qw), 32'h00);
    chk("rst_q_sat", 32'(qs), 32'h00);
    chk("rst_err", 32'(errw), 32'h0);
    chk("rst_co", 32'(cow), 32'h0);
    chk("rst_bo", 32'(bow), 32'h0);
    chk("rst_q3", 32'(q3), 32'h000);

    // full up walk 00..99 then wrap; saturate copy sticks at 99
    en = 1'b1; up = 1'b1; lim = 8'h99;
    #1;
    for (int i = 0; i < 100; i++) begin
      chk("walk_q", 32'(qw), 32'(to_bcd2(i)));
      chk("walk_co", 32'(cow), (i == 99) ? 32'h1 : 32'h0);
      tick();
    end
    chk("wrap_to_00", 32'(qw), 32'h00);
    chk("sat_hold_99", 32'(qs), 32'h99);
    chk("sat_co_99", 32'(cos), 32'h1);

    // down from 00 with Lim=59
    en = 1'b0; up = 1'b0; lim = 8'h59; clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_q_wrap", 32'(qw), 32'h00);
    chk("clr_q_sat", 32'(qs), 32'h00);
    en = 1'b1;
    #1;
    chk("bo_at_00_wrap", 32'(bow), 32'h1);
    chk("bo_at_00_sat", 32'(bos), 32'h1);
    tick();
    chk("down_wrap_59", 32'(qw), 32'h59);
    chk("down_sat_00", 32'(qs), 32'h00);
    chk("down_sat_bo", 32'(bos), 32'h1);
    tick();
    chk("down_58", 32'(qw), 32'h58);

    // enable low: hold, no flags
    en = 1'b0;
    #1;
    chk("hold_co", 32'(cow), 32'h0);
    chk("hold_bo", 32'(bow), 32'h0);
    tick();
    chk("hold_q", 32'(qw), 32'h58);

    // loads against Lim=59
    ld = 1'b1; d = 8'h47;
    tick();
    chk("ld_47_q", 32'(qw), 32'h47);
    chk("ld_47_err", 32'(errw), 32'h0);
    d = 8'h3A;
    tick();
    chk("ld_3A_q", 32'(qw), 32'h59);
    chk("ld_3A_err", 32'(errw), 32'h1);
    ld = 1'b0;
    tick();
    chk("err_one_cycle", 32'(errw), 32'h0);
    chk("ld_3A_hold", 32'(qw), 32'h59);
    ld = 1'b1; d = 8'h75;
    tick();
    chk("ld_75_q", 32'(qw), 32'h59);
    chk("ld_75_err", 32'(errw), 32'h1);
    d = 8'h59;
    tick();
    chk("ld_eq_lim_q", 32'(qw), 32'h59);
    chk("ld_eq_lim_err", 32'(errw), 32'h0);

    // non-BCD limit digit treated as 9
    lim = 8'h5F; d = 8'h58;
    tick();
    chk("lim5F_ld58_q", 32'(qw), 32'h58);
    chk("lim5F_ld58_err", 32'(errw), 32'h0);
    d = 8'h5A;
    tick();
    chk("lim5F_ld5A_q", 32'(qw), 32'h59);
    chk("lim5F_ld5A_err", 32'(errw), 32'h1);

    // lower Lim while counting down, then count up past it
    lim = 8'h59; d = 8'h50;
    tick();
    chk("ld_50", 32'(qw), 32'h50);
    ld = 1'b0; en = 1'b1; up = 1'b0; lim = 8'h30;
    tick();
    chk("lim_drop_wrap", 32'(qw), 32'h30);
    chk("lim_drop_sat", 32'(qs), 32'h30);
    up = 1'b1;
    #1;
    chk("co_at_lim", 32'(cow), 32'h1);
    tick();
    chk("up_wrap_00", 32'(qw), 32'h00);
    chk("up_sat_30", 32'(qs), 32'h30);

    // Lim = 0
    lim = 8'h00;
    #1;
    chk("lim0_co", 32'(cow), 32'h1);
    tick();
    chk("lim0_up_q", 32'(qw), 32'h00);
    chk("lim0_up_sat_q", 32'(qs), 32'h00);
    up = 1'b0;
    #1;
    chk("lim0_bo", 32'(bow), 32'h1);
    tick();
    chk("lim0_down_q", 32'(qw), 32'h00);

    // Clr beats Ld and En; Clr mid-count
    en = 1'b0; ld = 1'b1; d = 8'h42; lim = 8'h59;
    tick();
    chk("ld_42", 32'(qw), 32'h42);
    clr = 1'b1; en = 1'b1; up = 1'b1; d = 8'h12;
    tick();
    chk("clr_prio_q", 32'(qw), 32'h00);
    chk("clr_prio_err", 32'(errw), 32'h0);
    clr = 1'b0; en = 1'b0; d = 8'h55;
    tick();
    ld = 1'b0; en = 1'b1; up = 1'b1;
    tick();
    tick();
    chk("count_57", 32'(qw), 32'h57);
    clr = 1'b1;
    tick();
    chk("clr_mid_count", 32'(qw), 32'h00);
    clr = 1'b0; en = 1'b0;

    // three digits: 199 -> 200 -> 199
    ld3 = 1'b1; d3 = 12'h199; lim3 = 12'h999;
    tick();
    chk("d3_ld_199", 32'(q3), 32'h199);
    ld3 = 1'b0; en3 = 1'b1; up3 = 1'b1;
    tick();
    chk("d3_up_200", 32'(q3), 32'h200);
    up3 = 1'b0;
    tick();
    chk("d3_down_199", 32'(q3), 32'h199);
    en3 = 1'b0;

    // cascade: 0099 -> 0100 on one edge
    ld_c = 1'b1; d_lo = 8'h99; d_hi = 8'h00; lim_c = 8'h99;
    tick();
    chk("casc_ld", 32'({q_hi, q_lo}), 32'h0099);
    ld_c = 1'b0; en_c = 1'b1;
    #1;
    chk("casc_co_lo", 32'(co_lo), 32'h1);
    tick();
    chk("casc_roll", 32'({q_hi, q_lo}), 32'h0100);
    tick();
    chk("casc_next", 32'({q_hi, q_lo}), 32'h0101);
    en_c = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_bcd_ctr_n
`default_nettype wire
